// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle handshaked ALU: single-cycle logic/arith ops, bit-serial shifts
// Outputs are registered and change only on entry to DONE.
module alu_iter #(
  parameter int reg_width = 8,
  parameter int op_width  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [reg_width-1:0] ra_in,
  input  logic [reg_width-1:0] rb_in,
  input  logic [op_width-1:0]  op,
  output logic                 busy,
  output logic                 done,
  output logic [reg_width-1:0] res_out,
  output logic [reg_width-1:0] car_out,
  output logic                 zero,
  output logic                 jump
);

  localparam int cw = $clog2(reg_width + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [op_width-1:0] OP_ADD = op_width'(0);
  localparam logic [op_width-1:0] OP_SUB = op_width'(1);
  localparam logic [op_width-1:0] OP_AND = op_width'(2);
  localparam logic [op_width-1:0] OP_SRL = op_width'(3);
  localparam logic [op_width-1:0] OP_SLL = op_width'(4);
  localparam logic [op_width-1:0] OP_OR  = op_width'(5);
  localparam logic [op_width-1:0] OP_XOR = op_width'(6);
  localparam logic [op_width-1:0] OP_BEQ = op_width'(7);

  localparam logic [cw-1:0] width_c = cw'(reg_width);

  logic [1:0]           state;
  logic [cw-1:0]        cnt;
  logic [cw-1:0]        k0;
  logic                 sh_srl;
  logic [reg_width-1:0] sh_res;
  logic [reg_width-1:0] sh_car;

  logic [cw-1:0]        k_in;
  logic                 is_shift;
  logic [reg_width:0]   wide;
  logic [reg_width-1:0] alu_res;
  logic [reg_width-1:0] alu_car;
  logic                 alu_jump;
  logic [reg_width-1:0] res_nx;
  logic [reg_width-1:0] car_nx;
  logic [reg_width-1:0] car_fin;

  // Shift amount saturates at reg_width instead of wrapping.
  always_comb begin
    k_in     = (rb_in < reg_width) ? cw'(rb_in) : width_c;
    is_shift = (op == OP_SRL) || (op == OP_SLL);
  end

  always_comb begin
    wide     = '0;
    alu_res  = '0;
    alu_car  = '0;
    alu_jump = 1'b0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, ra_in} + {1'b0, rb_in};
        alu_res = wide[reg_width-1:0];
        alu_car = reg_width'(wide[reg_width]);
      end
      OP_SUB: begin
        wide    = {1'b0, ra_in} - {1'b0, rb_in};
        alu_res = wide[reg_width-1:0];
        alu_car = reg_width'(wide[reg_width]);
      end
      OP_AND: alu_res = ra_in & rb_in;
      OP_OR:  alu_res = ra_in | rb_in;
      OP_XOR: alu_res = ra_in ^ rb_in;
      OP_SRL: alu_res = ra_in;
      OP_SLL: alu_res = ra_in;
      OP_BEQ: alu_jump = (ra_in == rb_in);
      default: alu_res = '0;
    endcase
  end

  // SRL collects shifted-out bits from the top down, so they are right-justified at the end.
  always_comb begin
    if (sh_srl) begin
      res_nx  = {1'b0, sh_res[reg_width-1:1]};
      car_nx  = {sh_res[0], sh_car[reg_width-1:1]};
      car_fin = car_nx >> (width_c - k0);
    end else begin
      res_nx  = {sh_res[reg_width-2:0], 1'b0};
      car_nx  = {sh_car[reg_width-2:0], sh_res[reg_width-1]};
      car_fin = car_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      k0      <= '0;
      sh_srl  <= 1'b0;
      sh_res  <= '0;
      sh_car  <= '0;
      res_out <= '0;
      car_out <= '0;
      zero    <= 1'b0;
      jump    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_shift && (k_in != '0)) begin
              cnt    <= k_in;
              k0     <= k_in;
              sh_srl <= (op == OP_SRL);
              sh_res <= ra_in;
              sh_car <= '0;
              state  <= S_SHIFT;
            end else begin
              res_out <= alu_res;
              car_out <= alu_car;
              zero    <= (alu_res == '0);
              jump    <= alu_jump;
              state   <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          sh_res <= res_nx;
          sh_car <= car_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == cw'(1)) begin
            res_out <= res_nx;
            car_out <= car_fin;
            zero    <= (res_nx == '0);
            jump    <= 1'b0;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - table-driven self-checking bench for alu_iter
module tb_alu_iter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ra_in = '0;
  logic [7:0] rb_in = '0;
  logic [2:0] op = '0;
  logic       busy, done, zero, jump;
  logic [7:0] res_out, car_out;

  int errors = 0;
  int checks = 0;

  alu_iter #(.reg_width(8), .op_width(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ra_in(ra_in), .rb_in(rb_in), .op(op),
    .busy(busy), .done(done), .res_out(res_out), .car_out(car_out), .zero(zero), .jump(jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] res;
    logic [7:0] car;
    logic       zero;
    logic       jump;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns cycles from the start edge to the done cycle (99 on timeout).
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    op = o; ra_in = a; rb_in = b; start = 1'b1;
    lat = 99;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone;
    logic [7:0] hold_res;

    vecs[0]  = '{3'd3, 8'hF0, 8'h03, 8'h1E, 8'h00, 1'b0, 1'b0, 4};
    vecs[1]  = '{3'd3, 8'hF0, 8'h05, 8'h07, 8'h10, 1'b0, 1'b0, 6};
    vecs[2]  = '{3'd4, 8'hF0, 8'h02, 8'hC0, 8'h03, 1'b0, 1'b0, 3};
    vecs[3]  = '{3'd3, 8'hF0, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b0, 1};
    vecs[4]  = '{3'd3, 8'hF0, 8'h09, 8'h00, 8'hF0, 1'b1, 1'b0, 9};
    vecs[5]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b1, 1'b0, 1};
    vecs[6]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 8'h01, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd7, 8'h5A, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1, 1};
    vecs[8]  = '{3'd7, 8'h5A, 8'h5B, 8'h00, 8'h00, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd5, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0, 1};
    vecs[11] = '{3'd6, 8'hFF, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1};
    vecs[12] = '{3'd4, 8'h81, 8'h08, 8'h00, 8'h81, 1'b1, 1'b0, 9};
    vecs[13] = '{3'd3, 8'h81, 8'h01, 8'h40, 8'h01, 1'b0, 1'b0, 2};
    vecs[14] = '{3'd1, 8'h05, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0, 1};

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", res_out, 0);
    check("rst_car", car_out, 0);
    check("rst_zero", zero, 0);
    check("rst_jump", jump, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].ra, vecs[i].rb, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_res", i), res_out, vecs[i].res);
      check($sformatf("v%0d_car", i), car_out, vecs[i].car);
      check($sformatf("v%0d_zero", i), zero, vecs[i].zero);
      check($sformatf("v%0d_jump", i), jump, vecs[i].jump);
      hold_res = vecs[i].res;
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), done, 0);
      check($sformatf("v%0d_hold", i), res_out, hold_res);
    end

    // busy profile for SLL by 2: busy in cycles 1..3, done only in cycle 3
    op = 3'd4; ra_in = 8'hF0; rb_in = 8'h02; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("sll_busy_c%0d", c), busy, (c <= 3) ? 1 : 0);
      check($sformatf("sll_done_c%0d", c), done, (c == 3) ? 1 : 0);
    end

    // start held high through a 7-bit SRL while operands change: one done, latched operands used
    op = 3'd3; ra_in = 8'hF0; rb_in = 8'h07; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 3'd0; ra_in = 8'h00; rb_in = 8'h01;
    ndone = 0;
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        ndone++;
        if (lat == 99) lat = c;
        start = 1'b0;
      end
    end
    check("held_ndone", ndone, 1);
    check("held_lat", lat, 8);
    check("held_res", res_out, 8'h01);
    check("held_car", car_out, 8'h70);

    // reset in the middle of a shift aborts it
    run_op(3'd0, 8'h10, 8'h20, lat);
    @(negedge clk);
    op = 3'd3; ra_in = 8'hF0; rb_in = 8'h07; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", res_out, 0);
    check("abort_car", car_out, 0);
    check("abort_zero", zero, 0);
    check("abort_jump", jump, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    run_op(3'd0, 8'h01, 8'h01, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_res", res_out, 8'h02);
    check("post_rst_car", car_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
